// File: rtl/trail_buffer_if.sv
// Bus bundle for trail_buffer: head input, frame strobe, control and
// the indexed read port. The master side drives the head and the
// controls; the slave side is the buffer itself.
interface trail_buffer_if #(
   parameter int IDX_W = 6
);
   logic             frame_clk;
   logic [9:0]       HeadX;
   logic [9:0]       HeadY;
   logic             grow;
   logic             clear;
   logic [IDX_W-1:0] rd_idx;
   logic [9:0]       rd_x;
   logic [9:0]       rd_y;
   logic             rd_valid;
   logic [IDX_W:0]   Length;
   logic [IDX_W:0]   valid_len;
   logic             busy;
   logic             scan_done;
   logic             collide;

   modport master (
      output frame_clk, HeadX, HeadY, grow, clear, rd_idx,
      input  rd_x, rd_y, rd_valid, Length, valid_len, busy, scan_done, collide
   );

   modport slave (
      input  frame_clk, HeadX, HeadY, grow, clear, rd_idx,
      output rd_x, rd_y, rd_valid, Length, valid_len, busy, scan_done, collide
   );
endinterface

// File: rtl/trail_buffer.sv
// Snake/trail history. Once per frame the ball head position is pushed
// into a circular buffer of the last Length positions, then the body is
// scanned one entry per cycle for self-collision. A second read port
// serves the colour mapper without stalling the scan.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a frame tick (or a tick left pending)
// SCAN    | one body entry read per cycle, compared one cycle later
// DONE    | scan_done pulse, back to IDLE next cycle
module trail_buffer #(
   parameter int DEPTH    = 64,
   parameter int IDX_W    = 6,
   parameter int INIT_LEN = 4
) (
   input logic          Clk,
   input logic          Reset_n,
   trail_buffer_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [IDX_W:0] LP_DEPTH = DEPTH[IDX_W:0];
   localparam logic [IDX_W:0] LP_INIT  = INIT_LEN[IDX_W:0];

   logic [19:0]      r_mem [DEPTH];
   logic [19:0]      r_scan_q;

   logic             r_fc_s1;
   logic             r_fc_s2;
   logic             r_fc_s3;
   logic             r_tick;

   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_wr_ptr;
   logic [IDX_W:0]   r_valid_len;
   logic [IDX_W:0]   r_length;
   logic [19:0]      r_head;
   logic             r_grow_pending;
   logic             r_tick_pending;
   logic [IDX_W:0]   r_scan_cnt;
   logic [IDX_W-1:0] r_scan_addr;
   logic             r_cmp_vld;
   logic             r_collide;
   logic             r_scan_done;

   logic [9:0]       r_rd_x;
   logic [9:0]       r_rd_y;
   logic             r_rd_valid;

   logic             w_idle;
   logic             w_service;
   logic [19:0]      w_head;
   logic             w_same;
   logic             w_push;
   logic [IDX_W:0]   w_len_next;
   logic [IDX_W:0]   w_vlen_inc;
   logic [IDX_W:0]   w_vlen_next;
   logic [IDX_W-1:0] w_rd_addr;

   // r_head always equals entry[wr_ptr-1] once anything has been pushed,
   // so the stationary-head test needs no extra memory read port.
   assign w_idle      = (r_state == ST_IDLE);
   assign w_service   = w_idle & (r_tick | r_tick_pending);
   assign w_head      = {bus.HeadX, bus.HeadY};
   assign w_same      = (r_valid_len != '0) && (w_head == r_head);
   assign w_push      = w_service & ~w_same & ~bus.clear;
   assign w_len_next  = (r_grow_pending && (r_length < LP_DEPTH)) ? r_length + 1'b1 : r_length;
   assign w_vlen_inc  = r_valid_len + 1'b1;
   assign w_vlen_next = (w_vlen_inc > w_len_next) ? w_len_next : w_vlen_inc;
   assign w_rd_addr   = r_wr_ptr - 1'b1 - bus.rd_idx;

   // frame_clk synchronizer and registered rising-edge tick
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_fc_s1 <= 1'b0;
         r_fc_s2 <= 1'b0;
         r_fc_s3 <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_fc_s1 <= bus.frame_clk;
         r_fc_s2 <= r_fc_s1;
         r_fc_s3 <= r_fc_s2;
         r_tick  <= r_fc_s2 & ~r_fc_s3;
      end
   end

   // history storage: head write on push, pipelined scan read
   always_ff @(posedge Clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_head;
      end
      r_scan_q <= r_mem[r_scan_addr];
   end

   // push decision, length bookkeeping and scan FSM
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state        <= ST_IDLE;
         r_wr_ptr       <= '0;
         r_valid_len    <= '0;
         r_length       <= LP_INIT;
         r_head         <= '0;
         r_grow_pending <= 1'b0;
         r_tick_pending <= 1'b0;
         r_scan_cnt     <= '0;
         r_scan_addr    <= '0;
         r_cmp_vld      <= 1'b0;
         r_collide      <= 1'b0;
         r_scan_done    <= 1'b0;
      end else if (bus.clear) begin
         r_state        <= ST_IDLE;
         r_wr_ptr       <= '0;
         r_valid_len    <= '0;
         r_length       <= LP_INIT;
         r_grow_pending <= 1'b0;
         r_tick_pending <= 1'b0;
         r_scan_cnt     <= '0;
         r_cmp_vld      <= 1'b0;
         r_collide      <= 1'b0;
         r_scan_done    <= 1'b0;
      end else begin
         r_scan_done <= 1'b0;

         // a grow seen in the push cycle counts toward the next push
         if (w_push) begin
            r_grow_pending <= bus.grow;
         end else if (bus.grow) begin
            r_grow_pending <= 1'b1;
         end

         // at most one tick is remembered while the scan is busy
         if (w_service) begin
            r_tick_pending <= 1'b0;
         end else if (r_tick && !w_idle) begin
            r_tick_pending <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               r_cmp_vld <= 1'b0;
               if (w_push) begin
                  r_wr_ptr    <= r_wr_ptr + 1'b1;
                  r_head      <= w_head;
                  r_length    <= w_len_next;
                  r_valid_len <= w_vlen_next;
                  r_scan_cnt  <= w_vlen_next - 1'b1;
                  r_scan_addr <= r_wr_ptr - 1'b1;
                  r_state     <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // while cnt is nonzero a read is issued; its data is
               // compared in the following cycle
               r_cmp_vld   <= (r_scan_cnt != '0);
               r_scan_addr <= r_scan_addr - 1'b1;
               if (r_cmp_vld && (r_scan_q == r_head)) begin
                  r_collide <= 1'b1;
               end
               if (r_scan_cnt == '0) begin
                  r_state     <= ST_DONE;
                  r_scan_done <= 1'b1;
               end else begin
                  r_scan_cnt <= r_scan_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               r_cmp_vld <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_cmp_vld <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // independent registered read port; sees pre-push contents
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_rd_x     <= '0;
         r_rd_y     <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_x     <= r_mem[w_rd_addr][19:10];
         r_rd_y     <= r_mem[w_rd_addr][9:0];
         r_rd_valid <= ({1'b0, bus.rd_idx} < r_valid_len);
      end
   end

   assign bus.rd_x      = r_rd_x;
   assign bus.rd_y      = r_rd_y;
   assign bus.rd_valid  = r_rd_valid;
   assign bus.Length    = r_length;
   assign bus.valid_len = r_valid_len;
   assign bus.busy      = ~w_idle;
   assign bus.scan_done = r_scan_done;
   assign bus.collide   = r_collide;

endmodule

// File: tb/tb_trail_buffer.sv
// Scoreboard bench for trail_buffer: stimulus tasks queue the expected
// scan results and read data; monitors pop and compare when the DUT
// presents scan_done or a read result.
module tb_trail_buffer;

   logic Clk;
   logic Reset_n;

   trail_buffer_if #(.IDX_W(6)) bus ();

   trail_buffer #(.DEPTH(64), .IDX_W(6), .INIT_LEN(4)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic       col;
      logic [6:0] vl;
      logic [6:0] len;
   } scan_exp_t;

   typedef struct packed {
      logic       v;
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] idx;
   } rd_exp_t;

   scan_exp_t scan_q[$];
   rd_exp_t   rd_q[$];
   bit        rd_armed;
   int        total;
   int        bad;

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // scan result monitor
   initial begin
      scan_exp_t e;
      forever begin
         @(negedge Clk);
         if (Reset_n && bus.scan_done === 1'b1) begin
            if (scan_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_scan_done actual=1 required=0 t=%0t", $time);
            end else begin
               e = scan_q.pop_front();
               chk("scan_collide", 32'(bus.collide), 32'(e.col));
               chk("scan_valid_len", 32'(bus.valid_len), 32'(e.vl));
               chk("scan_length", 32'(bus.Length), 32'(e.len));
            end
         end
      end
   end

   // read port monitor: compares one cycle after the index was applied
   initial begin
      rd_exp_t r;
      forever begin
         @(posedge Clk);
         if (rd_armed) begin
            rd_armed = 1'b0;
            @(negedge Clk);
            r = rd_q.pop_front();
            chk($sformatf("rd_valid[%0d]", r.idx), 32'(bus.rd_valid), 32'(r.v));
            if (r.v) begin
               chk($sformatf("rd_x[%0d]", r.idx), 32'(bus.rd_x), 32'(r.x));
               chk($sformatf("rd_y[%0d]", r.idx), 32'(bus.rd_y), 32'(r.y));
            end
         end
      end
   end

   initial begin
      #1_200_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic rd_req(input int idx, input bit v, input int x, input int y);
      @(posedge Clk); #1;
      bus.rd_idx = 6'(idx);
      rd_q.push_back(rd_exp_t'{v, 10'(x), 10'(y), 6'(idx)});
      rd_armed = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 200) begin
         @(negedge Clk);
         if (!bus.busy) break;
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (n < 20) begin
         @(negedge Clk);
         if (bus.busy) break;
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL busy_timeout actual=idle required=busy");
      end
   endtask

   task automatic do_tick(input int x, input int y, input bit exp_scan,
                          input bit ec, input int evl, input int elen);
      @(posedge Clk); #1;
      bus.HeadX = 10'(x);
      bus.HeadY = 10'(y);
      if (exp_scan) scan_q.push_back(scan_exp_t'{ec, 7'(evl), 7'(elen)});
      bus.frame_clk = 1'b1;
      repeat (6) @(posedge Clk);
      #1;
      bus.frame_clk = 1'b0;
      wait_idle();
      repeat (3) @(posedge Clk);
      #1;
   endtask

   task automatic pulse_grow();
      @(posedge Clk); #1;
      bus.grow = 1'b1;
      @(posedge Clk); #1;
      bus.grow = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge Clk); #1;
      bus.clear = 1'b1;
      @(posedge Clk); #1;
      bus.clear = 1'b0;
   endtask

   task automatic chk_drained(input string nm);
      chk(nm, 32'(scan_q.size()), 32'd0);
   endtask

   initial begin
      int len;
      int vl;
      bit pend;
      total         = 0;
      bad           = 0;
      rd_armed      = 1'b0;
      Reset_n       = 1'b0;
      bus.frame_clk = 1'b0;
      bus.HeadX     = '0;
      bus.HeadY     = '0;
      bus.grow      = 1'b0;
      bus.clear     = 1'b0;
      bus.rd_idx    = '0;

      // 1. reset state
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_rd_x", 32'(bus.rd_x), 0);
      chk("rst_rd_y", 32'(bus.rd_y), 0);
      chk("rst_scan_done", 32'(bus.scan_done), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      chk("rst_length", 32'(bus.Length), 4);
      chk("rst_valid_len", 32'(bus.valid_len), 0);
      chk("rst_collide", 32'(bus.collide), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      for (int i = 0; i < 64; i++) rd_req(i, 1'b0, 0, 0);

      // 2. fill and history
      for (int i = 0; i < 5; i++) begin
         do_tick(320 + i, 240, 1'b1, 1'b0, (i + 1 > 4) ? 4 : i + 1, 4);
      end
      chk_drained("fill_scan_count");
      chk("fill_valid_len", 32'(bus.valid_len), 4);
      rd_req(0, 1'b1, 324, 240);
      rd_req(1, 1'b1, 323, 240);
      rd_req(3, 1'b1, 321, 240);
      rd_req(4, 1'b0, 0, 0);

      // 3. stationary head
      pulse_clear();
      do_tick(100, 100, 1'b1, 1'b0, 1, 4);
      do_tick(100, 100, 1'b0, 1'b0, 0, 0);
      repeat (10) @(posedge Clk);
      chk_drained("stationary_scan_count");
      @(negedge Clk);
      chk("stationary_valid_len", 32'(bus.valid_len), 1);

      // 4a. square path, old (10,10) aged out at Length 4
      pulse_clear();
      do_tick(10, 10, 1'b1, 1'b0, 1, 4);
      do_tick(11, 10, 1'b1, 1'b0, 2, 4);
      do_tick(11, 11, 1'b1, 1'b0, 3, 4);
      do_tick(10, 11, 1'b1, 1'b0, 4, 4);
      do_tick(10, 10, 1'b1, 1'b0, 4, 4);
      // 4b. same path at Length 5 closes on itself
      pulse_clear();
      pulse_grow();
      do_tick(10, 10, 1'b1, 1'b0, 1, 5);
      do_tick(11, 10, 1'b1, 1'b0, 2, 5);
      do_tick(11, 11, 1'b1, 1'b0, 3, 5);
      do_tick(10, 11, 1'b1, 1'b0, 4, 5);
      do_tick(10, 10, 1'b1, 1'b1, 5, 5);
      chk_drained("square_scan_count");
      @(negedge Clk);
      chk("square_collide_sticky", 32'(bus.collide), 1);

      // 5. grow merge, saturation and wrap
      pulse_clear();
      pulse_grow();
      pulse_grow();
      pulse_grow();
      len  = 4;
      vl   = 0;
      pend = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (i >= 1 && i <= 59) begin
            pulse_grow();
            pend = 1'b1;
         end
         if (pend && len < 64) len++;
         pend = 1'b0;
         vl   = (vl + 1 > len) ? len : vl + 1;
         do_tick(i, 500, 1'b1, 1'b0, vl, len);
         if (i == 0) chk("grow_merge_length", 32'(bus.Length), 5);
      end
      chk("sat_length", 32'(bus.Length), 64);
      chk("sat_valid_len", 32'(bus.valid_len), 64);
      rd_req(63, 1'b1, 6, 500);
      rd_req(0, 1'b1, 69, 500);
      pulse_grow();
      do_tick(70, 500, 1'b1, 1'b0, 64, 64);
      chk_drained("wrap_scan_count");

      // 6a. tick during SCAN is serviced after DONE
      @(posedge Clk); #1;
      bus.HeadX = 10'd200;
      bus.HeadY = 10'd1;
      scan_q.push_back(scan_exp_t'{1'b0, 7'd64, 7'd64});
      bus.frame_clk = 1'b1;
      wait_busy();
      #1;
      bus.HeadX = 10'd201;
      bus.frame_clk = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      bus.frame_clk = 1'b1;
      scan_q.push_back(scan_exp_t'{1'b0, 7'd64, 7'd64});
      repeat (6) @(posedge Clk);
      #1;
      bus.frame_clk = 1'b0;
      wait_idle();
      repeat (2) @(posedge Clk);
      wait_idle();
      repeat (3) @(posedge Clk);
      chk_drained("pending_scan_count");
      rd_req(0, 1'b1, 201, 1);
      rd_req(1, 1'b1, 200, 1);
      rd_req(2, 1'b1, 70, 500);

      // 6b. clear during SCAN aborts with no scan_done
      @(posedge Clk); #1;
      bus.HeadX = 10'd300;
      bus.HeadY = 10'd2;
      bus.frame_clk = 1'b1;
      wait_busy();
      repeat (10) @(posedge Clk);
      #1;
      bus.clear = 1'b1;
      @(posedge Clk); #1;
      bus.clear = 1'b0;
      bus.frame_clk = 1'b0;
      @(negedge Clk);
      chk("clr_busy", 32'(bus.busy), 0);
      chk("clr_valid_len", 32'(bus.valid_len), 0);
      chk("clr_length", 32'(bus.Length), 4);
      chk("clr_collide", 32'(bus.collide), 0);
      repeat (80) @(posedge Clk);
      chk_drained("clr_no_scan_done");
      rd_req(0, 1'b0, 0, 0);

      // 6c. reset during SCAN
      do_tick(1, 1, 1'b1, 1'b0, 1, 4);
      do_tick(2, 1, 1'b1, 1'b0, 2, 4);
      do_tick(1, 1, 1'b1, 1'b1, 3, 4);
      @(posedge Clk); #1;
      bus.HeadX = 10'd3;
      bus.frame_clk = 1'b1;
      wait_busy();
      @(negedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_scan_done", 32'(bus.scan_done), 0);
      chk("arst_collide", 32'(bus.collide), 0);
      chk("arst_length", 32'(bus.Length), 4);
      chk("arst_valid_len", 32'(bus.valid_len), 0);
      chk("arst_rd_valid", 32'(bus.rd_valid), 0);
      chk("arst_rd_x", 32'(bus.rd_x), 0);
      chk("arst_rd_y", 32'(bus.rd_y), 0);
      bus.frame_clk = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      repeat (20) @(posedge Clk);
      chk_drained("arst_no_scan_done");
      @(negedge Clk);
      chk("arst_busy_after", 32'(bus.busy), 0);

      repeat (3) @(posedge Clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trail_buffer.md
Name: trail_buffer

Overview:
- Sits directly downstream of the ball motion block. Its inputs are the ball's head position, BallX/BallY, truncated to 10 bits.
- Records the head position once per frame in a circular history of the last Length positions. This is the snake/trail body.
- After every push, scans the body sequentially for self-collision.
- Exposes an indexed read port so the colour mapper and game logic can fetch any body segment.

Parameters:
- DEPTH, 64: history capacity; must be a power of 2.
- IDX_W, 6: log2(DEPTH).
- INIT_LEN, 4: body length after reset or clear; 1 <= INIT_LEN <= DEPTH.

Ports:
- Clk, in, 1: system clock (50 MHz).
- Reset_n, in, 1: asynchronous, active-low reset.
- frame_clk, in, 1: vsync-rate frame strobe, asynchronous to Clk.
- HeadX, in, 10: current head X position.
- HeadY, in, 10: current head Y position.
- grow, in, 1: one-cycle request to lengthen the body by 1.
- clear, in, 1: synchronous restart of the history.
- rd_idx, in, IDX_W: segment index; 0 is the newest (head).
- rd_x, out, 10: X of the segment at rd_idx, registered.
- rd_y, out, 10: Y of the segment at rd_idx, registered.
- rd_valid, out, 1: registered; 1 when rd_idx < valid_len.
- Length, out, IDX_W+1: current target body length.
- valid_len, out, IDX_W+1: number of entries actually written, min(pushes, Length).
- busy, out, 1: high while the scan FSM is not IDLE.
- scan_done, out, 1: one-cycle pulse when a scan completes.
- collide, out, 1: sticky self-collision flag.

Behaviour:
- Reset values (Reset_n low, asynchronous):
  - wr_ptr=0, valid_len=0, Length=INIT_LEN.
  - collide=0, scan_done=0, busy=0.
  - rd_x=rd_y=0, rd_valid=0.
  - grow_pending=0, tick_pending=0, FSM=IDLE.
  - Storage contents are don't-care.
- Tick detection:
  - frame_clk passes through a 2-FF synchronizer, then a rising-edge detect.
  - tick is high for one Clk, 3 Clk after the frame_clk rise.
- grow:
  - Any pulse sets grow_pending.
  - Multiple pulses before the next push merge into a single +1.
- Push decision: on tick (or on tick_pending) while in IDLE:
  - If valid_len>0 and {HeadX,HeadY} equals entry[wr_ptr-1], there is no push and no scan; grow_pending is retained.
  - Otherwise, write {HeadX,HeadY} to entry[wr_ptr] and increment wr_ptr modulo DEPTH.
- Length and valid_len update, on a push:
  - If grow_pending and Length<DEPTH: Length+=1.
  - grow_pending is cleared even when Length==DEPTH; a grow at capacity is dropped.
  - valid_len = min(valid_len+1, new Length).
  - The FSM then enters SCAN.
- FSM states: IDLE -> SCAN -> DONE -> IDLE.
- SCAN:
  - k runs from 1 to valid_len-1, one entry per cycle.
  - Each step compares entry[wr_ptr-1-k], mod DEPTH, against the new head.
  - The storage read has 1-cycle latency, so comparisons are pipelined.
  - Any match sets collide.
  - If valid_len<=1, SCAN lasts exactly 1 cycle with no compare.
- DONE: scan_done=1 for one cycle, then IDLE.
- Scan latency: valid_len+1 Clk cycles from push to scan_done, at most DEPTH+1.
- Ticks during SCAN or DONE:
  - A tick arriving while not in IDLE sets tick_pending.
  - tick_pending is serviced on the first IDLE cycle.
  - Further ticks while tick_pending is already set are dropped.
- collide: stays 1 until clear or reset.
- clear (synchronous): highest priority over tick, grow and the scan.
  - Sets wr_ptr=0, valid_len=0, Length=INIT_LEN.
  - Sets collide=0, grow_pending=0, tick_pending=0, FSM=IDLE.
  - Aborts any scan in progress, with no scan_done.
- Reset mid-scan: same result as the reset values above; no scan_done pulse.
- Read port:
  - rd_x and rd_y are registered from entry[wr_ptr-1-rd_idx], mod DEPTH, with 1 Clk latency.
  - rd_valid is registered on the same cycle.
  - The read port is independent of the scan (second read port), so there is no stall.
  - If rd_valid=0, rd_x and rd_y are don't-care.
- Same-cycle push and read: the read returns pre-push contents.
- Width rules:
  - Pointer arithmetic is IDX_W bits and wraps naturally.
  - Length and valid_len are IDX_W+1 bits, so they can represent DEPTH.

Test Plan:
1. Reset check -> Length=4, valid_len=0, collide=0, busy=0, rd_valid=0 for every rd_idx.
2. Fill and history:
   - Stimulus: 5 ticks with heads (320,240) through (324,240), stepping X by 1.
   - Required: valid_len=4; rd_idx 0 reads (324,240); rd_idx 3 reads (321,240); rd_idx 4 gives rd_valid=0.
   - Required: scan_done pulses 5 times; collide=0.
3. Stationary head: two ticks with (100,100) -> second tick gives no push, no scan_done, valid_len=1.
4. Length boundary on collision:
   - Stimulus: Length=4, path (10,10), (11,10), (11,11), (10,11), (10,10) -> collide=0, because the old (10,10) has aged out.
   - Stimulus: repeat after a grow pulse (Length=5) -> collide=1 at the final scan_done.
5. Grow saturation and wrap:
   - Stimulus: 3 grow pulses, then 1 tick -> Length=5.
   - Stimulus: drive Length to 64, push 70 distinct heads -> Length=64, valid_len=64.
   - Required: rd_idx 63 reads the 7th head; wr_ptr has wrapped.
6. Mid-scan events:
   - Stimulus: tick during SCAN -> serviced after DONE, giving 2 scan_done pulses.
   - Stimulus: clear during SCAN -> immediate IDLE, valid_len=0, no scan_done.
   - Stimulus: Reset_n low during SCAN -> all outputs return to reset values asynchronously.
